// File: rtl/mxpl_writer_pkg.sv
`default_nettype none
// ============================================================================
// mxpl_writer_pkg : widths shared with conv/max-pool and writer FSM encoding
// Revision: 1.0
// ============================================================================
package mxpl_writer_pkg;

  localparam int DATAW = 20;
  localparam int ADDRW = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width that stays at least one bit for degenerate 1-wide maps.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mxpl_wr_fifo.sv
`default_nettype none
// ============================================================================
// mxpl_wr_fifo : 2-entry FIFO with registered head; push while full is dropped
// Revision: 1.0
// ============================================================================
module mxpl_wr_fifo #(
  parameter int DATAW = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [DATAW-1:0] r_head;
  logic [DATAW-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  // A full buffer still takes a new value when the head leaves in the same cycle.
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (clr) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_head;
  assign empty = (r_count == 2'd0);
  assign full  = (r_count == 2'd2);

endmodule
`default_nettype wire

// File: rtl/mxpl_writer.sv
`default_nettype none
// ============================================================================
// mxpl_writer : writes pooled values (optional ReLU) row-major into a padded map
// Revision: 1.0
// ============================================================================
module mxpl_writer #(
  parameter int DATAW = mxpl_writer_pkg::DATAW,
  parameter int ADDRW = mxpl_writer_pkg::ADDRW,
  parameter int MAP_W = 16,
  parameter int MAP_H = 16,
  parameter int PAD   = 1,
  parameter int PITCH = 18,
  parameter int BASE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             relu_en,
  input  logic [DATAW-1:0] result,
  input  logic             mxplDone,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  output logic             busy,
  output logic             layerDone,
  output logic             overflow
);

  import mxpl_writer_pkg::*;

  localparam int             CW      = cnt_w(MAP_W);
  localparam int             RW      = cnt_w(MAP_H);
  localparam logic [ADDRW-1:0] C_ROW0  = ADDRW'(BASE + PAD * PITCH);
  localparam logic [ADDRW-1:0] C_ADDR0 = ADDRW'(BASE + PAD * PITCH + PAD);
  localparam logic [ADDRW-1:0] C_PITCH = ADDRW'(PITCH);
  localparam logic [ADDRW-1:0] C_PAD   = ADDRW'(PAD);
  localparam logic [CW-1:0]    C_COL_L = CW'(MAP_W - 1);
  localparam logic [RW-1:0]    C_ROW_L = RW'(MAP_H - 1);

  state_t           r_state;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [ADDRW-1:0] r_row_base;
  logic [ADDRW-1:0] r_addr;
  logic             r_busy;
  logic             r_layer_done;
  logic             r_overflow;

  logic             w_start_run;
  logic             w_push;
  logic             w_we;
  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic [DATAW-1:0] w_relu_data;
  logic [DATAW-1:0] w_head;

  assign w_start_run = (r_state == ST_IDLE) && start;
  assign w_push      = (r_state == ST_RUN) && mxplDone;
  assign w_we        = (r_state == ST_RUN) && !w_empty;
  assign w_accept    = w_we && mem_ready;
  assign w_relu_data = (relu_en && result[DATAW-1]) ? '0 : result;

  mxpl_wr_fifo #(
    .DATAW (DATAW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_run),
    .push  (w_push),
    .pop   (w_accept),
    .din   (w_relu_data),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_row_base   <= C_ROW0;
      r_addr       <= C_ADDR0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= C_ROW0;
            r_addr     <= C_ADDR0;
            r_overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_push && w_full && !w_accept) r_overflow <= 1'b1;
          if (w_accept) begin
            if (r_col == C_COL_L) begin
              // Row wrap: step the row base by one pitch, no multiplier.
              r_col      <= '0;
              r_row      <= r_row + RW'(1);
              r_row_base <= r_row_base + C_PITCH;
              r_addr     <= r_row_base + C_PITCH + C_PAD;
              if (r_row == C_ROW_L) begin
                r_state      <= ST_DONE;
                r_busy       <= 1'b0;
                r_layer_done <= 1'b1;
              end
            end else begin
              r_col  <= r_col + CW'(1);
              r_addr <= r_addr + ADDRW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_layer_done <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_we    = w_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_head;
  assign busy      = r_busy;
  assign layerDone = r_layer_done;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mxpl_writer.sv
`default_nettype none
// ============================================================================
// tb_mxpl_writer : directed and randomized checks of mxpl_writer (2x2 and 16x16)
// Revision: 1.0
// ============================================================================
module tb_mxpl_writer;

  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          relu_en;
  logic [DW-1:0] result;
  logic          mxplDone;
  logic          mem_ready;

  logic          s_we, s_busy, s_done, s_ovf;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          w_we, w_busy, w_done, w_ovf;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mxpl_writer #(.DATAW(DW), .ADDRW(AW), .MAP_W(2), .MAP_H(2), .PAD(1), .PITCH(4), .BASE(0)) dut_s (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .result(result),
    .mxplDone(mxplDone), .mem_ready(mem_ready), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .busy(s_busy), .layerDone(s_done), .overflow(s_ovf));

  mxpl_writer #(.DATAW(DW), .ADDRW(AW), .MAP_W(16), .MAP_H(16), .PAD(1), .PITCH(18), .BASE(256)) dut_w (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .result(result),
    .mxplDone(mxplDone), .mem_ready(mem_ready), .mem_we(w_we), .mem_addr(w_addr),
    .mem_wdata(w_wdata), .busy(w_busy), .layerDone(w_done), .overflow(w_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Padded row-major placement of the k-th pooled value.
  function automatic int s_addr_of(input int k);
    return 0 + (k / 2 + 1) * 4 + (k % 2 + 1);
  endfunction

  function automatic int w_addr_of(input int k);
    return 256 + (k / 16 + 1) * 18 + (k % 16 + 1);
  endfunction

  function automatic logic [DW-1:0] relu_of(input bit r, input int v);
    if (r && v < 0) return '0;
    return DW'(v);
  endfunction

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; relu_en = 1'b0; result = '0; mxplDone = 1'b0; mem_ready = 1'b1;
    #12;
    checks++;
    if ({s_we, s_busy, s_done, s_ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {s_we, s_busy, s_done, s_ovf});
    end
    checks++;
    if ({s_addr, s_wdata} !== {AW'(5), DW'(0)}) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h expected 005/00000", s_addr, s_wdata);
    end
    checks++;
    if (w_addr !== AW'(12'h113)) begin
      errors++; $display("FAIL reset_addr_wide: got %h expected 113", w_addr);
    end
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_basic(input bit relu, input int v0, input int v1, input int v2, input int v3);
    int v[4];
    v = '{v0, v1, v2, v3};
    relu_en = relu; mem_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if ({s_busy, s_we} !== 2'b10) begin
      errors++; $display("FAIL basic_busy: got busy=%b we=%b expected busy=1 we=0", s_busy, s_we);
    end
    for (int i = 0; i < 6; i++) begin
      mxplDone = (i < 4);
      if (i < 4) result = DW'(v[i]);
      tick;
      checks++;
      if (i < 4) begin
        if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(s_addr_of(i)), relu_of(relu, v[i])}) begin
          errors++;
          $display("FAIL basic_write%0d relu=%0d: got we=%b %h@%h expected 1 %h@%h", i, relu,
                   s_we, s_wdata, s_addr, relu_of(relu, v[i]), AW'(s_addr_of(i)));
        end
      end else if (i == 4) begin
        if ({s_done, s_busy, s_we} !== 3'b100) begin
          errors++; $display("FAIL basic_done: got done=%b busy=%b we=%b expected 1 0 0", s_done, s_busy, s_we);
        end
      end else begin
        if ({s_done, s_ovf} !== 2'b00) begin
          errors++; $display("FAIL basic_done_pulse: got done=%b ovf=%b expected 0 0", s_done, s_ovf);
        end
      end
    end
  endtask

  task automatic test_overflow;
    relu_en = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    mem_ready = 1'b0; mxplDone = 1'b1;
    result = DW'(11); tick;
    result = DW'(22); tick;
    result = DW'(33); tick;
    checks++;
    if ({s_ovf, s_we, s_addr, s_wdata} !== {1'b1, 1'b1, AW'(5), DW'(11)}) begin
      errors++; $display("FAIL ovf_set: got ovf=%b we=%b %h@%h expected 1 1 0000b@005", s_ovf, s_we, s_wdata, s_addr);
    end
    mxplDone = 1'b0; mem_ready = 1'b1; tick;
    checks++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(6), DW'(22)}) begin
      errors++; $display("FAIL ovf_second: got we=%b %h@%h expected 1 00016@006", s_we, s_wdata, s_addr);
    end
    tick;
    checks++;
    if ({s_we, s_ovf} !== 2'b01) begin
      errors++; $display("FAIL ovf_dropped: got we=%b ovf=%b expected we=0 ovf=1", s_we, s_ovf);
    end
    mxplDone = 1'b1; result = DW'(44); tick;
    checks++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(9), DW'(44)}) begin
      errors++; $display("FAIL ovf_third: got we=%b %h@%h expected 1 0002c@009", s_we, s_wdata, s_addr);
    end
    result = DW'(55); tick;
    mxplDone = 1'b0; tick;
    checks++;
    if ({s_done, s_ovf} !== 2'b11) begin
      errors++; $display("FAIL ovf_sticky: got done=%b ovf=%b expected 1 1", s_done, s_ovf);
    end
    tick;
  endtask

  task automatic test_stall;
    int    exp_a[4];
    int    exp_d[4];
    exp_a = '{5, 6, 9, 10};
    exp_d = '{5, -3, 7, 0};
    relu_en = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if (s_ovf !== 1'b0) begin
      errors++; $display("FAIL stall_ovf_cleared: got %b expected 0", s_ovf);
    end
    mem_ready = 1'b0; mxplDone = 1'b1; result = DW'(5); tick;
    result = DW'(-3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(5), DW'(5)}) begin
        errors++; $display("FAIL stall_hold%0d: got we=%b %h@%h expected 1 00005@005", i, s_we, s_wdata, s_addr);
      end
      tick;
      mxplDone = 1'b0;
    end
    checks++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(5), DW'(5)}) begin
      errors++; $display("FAIL stall_hold3: got we=%b %h@%h expected 1 00005@005", s_we, s_wdata, s_addr);
    end
    // Release while full, pushing in the same cycle as the pop.
    mem_ready = 1'b1; mxplDone = 1'b1; result = DW'(7); tick;
    for (int i = 1; i < 4; i++) begin
      mxplDone = (i == 1);
      result = DW'(0);
      checks++;
      if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(exp_a[i]), DW'(exp_d[i])}) begin
        errors++;
        $display("FAIL stall_write%0d: got we=%b %h@%h expected 1 %h@%h", i, s_we, s_wdata, s_addr,
                 DW'(exp_d[i]), AW'(exp_a[i]));
      end
      tick;
    end
    checks++;
    if ({s_done, s_ovf} !== 2'b10) begin
      errors++; $display("FAIL stall_done: got done=%b ovf=%b expected 1 0", s_done, s_ovf);
    end
    tick;
  endtask

  task automatic test_control;
    mem_ready = 1'b1; relu_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mxplDone = 1'b1; result = DW'(77); tick;
      checks++;
      if ({s_we, s_busy, s_ovf} !== 3'b000) begin
        errors++; $display("FAIL idle_push%0d: got we=%b busy=%b ovf=%b expected 0 0 0", i, s_we, s_busy, s_ovf);
      end
    end
    mxplDone = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    mxplDone = 1'b1; result = DW'(1); tick;
    result = DW'(2); start = 1'b1; tick; start = 1'b0;
    checks++;
    if ({s_busy, s_we, s_addr, s_wdata} !== {1'b1, 1'b1, AW'(6), DW'(2)}) begin
      errors++; $display("FAIL start_in_run: got busy=%b we=%b %h@%h expected 1 1 00002@006", s_busy, s_we, s_wdata, s_addr);
    end
    result = DW'(3); tick;
    mxplDone = 1'b0; reset = 1'b0; #2;
    checks++;
    if ({s_we, s_busy, s_done, s_ovf, s_addr, s_wdata} !== {4'b0000, AW'(5), DW'(0)}) begin
      errors++; $display("FAIL abort_reset: got we=%b busy=%b done=%b ovf=%b %h@%h expected 0 0 0 0 00000@005",
                         s_we, s_busy, s_done, s_ovf, s_wdata, s_addr);
    end
    tick; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({s_we, s_busy, s_done} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet%0d: got we=%b busy=%b done=%b expected 0 0 0", i, s_we, s_busy, s_done);
      end
    end
    start = 1'b1; tick; start = 1'b0;
    mxplDone = 1'b1; result = DW'(8); tick;
    checks++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, AW'(5), DW'(8)}) begin
      errors++; $display("FAIL restart_addr: got we=%b %h@%h expected 1 00008@005", s_we, s_wdata, s_addr);
    end
    result = DW'(9); tick;
    result = DW'(10); tick;
    result = DW'(11); tick;
    mxplDone = 1'b0; tick;
    checks++;
    if (s_done !== 1'b1) begin
      errors++; $display("FAIL restart_done: got %b expected 1", s_done);
    end
    tick;
  endtask

  task automatic test_random_wrap;
    logic [DW-1:0] pq[$];
    int            k = 0;
    int            pushed = 0;
    int            cyc = 0;
    int            v;
    bit            done_seen = 1'b0;
    reset = 1'b0; mxplDone = 1'b0; start = 1'b0; tick;
    reset = 1'b1; tick;
    start = 1'b1; tick; start = 1'b0;
    while (cyc < 3000 && !done_seen) begin
      if (k == 256) begin
        checks++;
        if ({w_done, w_busy, w_we} !== 3'b100) begin
          errors++; $display("FAIL wrap_done: got done=%b busy=%b we=%b expected 1 0 0", w_done, w_busy, w_we);
        end
        done_seen = 1'b1;
      end else begin
        checks++;
        if (w_we !== (pq.size() > 0)) begin
          errors++; $display("FAIL wrap_we k=%0d: got %b expected %0d", k, w_we, pq.size() > 0);
        end
        if (pq.size() > 0) begin
          checks++;
          if ({w_addr, w_wdata} !== {AW'(w_addr_of(k)), pq[0]}) begin
            errors++; $display("FAIL wrap_write k=%0d: got %h@%h expected %h@%h", k, w_wdata, w_addr, pq[0], AW'(w_addr_of(k)));
          end
        end
        mem_ready = ($urandom_range(0, 3) != 0);
        if (pq.size() > 0 && mem_ready) begin
          if (k == 255) begin
            checks++;
            if (w_addr !== AW'(12'h230)) begin
              errors++; $display("FAIL wrap_last_addr: got %h expected 230", w_addr);
            end
          end
          void'(pq.pop_front());
          k++;
        end
        mxplDone = (pushed < 256) && (pq.size() < 2) && ($urandom_range(0, 3) != 0);
        relu_en  = 1'($urandom_range(0, 1));
        v        = int'($urandom_range(0, 32'h000F_FFFF)) - 32'sh0008_0000;
        result   = DW'(v);
        if (mxplDone) begin
          pq.push_back(relu_of(relu_en, v));
          pushed++;
        end
        tick;
        cyc++;
      end
    end
    mxplDone = 1'b0; mem_ready = 1'b1;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL wrap_timeout: got %0d accepts expected 256", k);
    end
    checks++;
    if (w_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_ovf: got %b expected 0", w_ovf);
    end
    tick;
    checks++;
    if (w_done !== 1'b0) begin
      errors++; $display("FAIL wrap_done_pulse: got %b expected 0", w_done);
    end
  endtask

  initial begin
    test_reset;
    test_basic(1'b0, 5, -3, 7, 0);
    test_basic(1'b1, 5, -3, 7, -524288);
    test_overflow;
    test_stall;
    test_control;
    test_random_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
